// File: rtl/qam_symbol_mapper.sv
// ============================================================================
// qam_symbol_mapper
// ----------------------------------------------------------------------------
// Purpose:
//   Takes right-aligned bit groups from the serial-to-parallel converter and
//   maps each one to a Gray-coded signed I/Q constellation point, either QPSK
//   or 16QAM. The mode travels with every symbol, so it can change on any
//   symbol boundary. Mapped symbols are buffered in a small first-word-fall-
//   through FIFO and presented to the pulse-shaping/DAC stage on a
//   valid/ready interface.
//
// Pipeline:
//   edge A : map register captures i_sym_in/i_sym_mod (i_sym_valid sampled)
//   edge B : mapped word enters the FIFO; if the FIFO was empty it is
//            presented on the output registers at this same edge
//
// Ports:
//   i_clk          in   1       single clock, rising edge
//   i_rst          in   1       synchronous reset, active-high
//   i_sym_in       in   4       bit group; QPSK uses [1:0], 16QAM uses [3:0]
//   i_sym_mod      in   1       0 = QPSK, 1 = 16QAM (qualified by i_sym_valid)
//   i_sym_valid    in   1       one strobe per bit group, no back-pressure
//   i_out_ready    in   1       downstream accepts the presented word
//   o_out_valid    out  1       o_i_out/o_q_out/o_out_mod hold a symbol
//   o_i_out        out  OUT_W   in-phase amplitude, two's complement
//   o_q_out        out  OUT_W   quadrature amplitude, two's complement
//   o_out_mod      out  1       mode of the presented symbol
//   o_fifo_level   out  clog2(FIFO_DEPTH)+1  entries held, incl. presented
//   o_overflow     out  1       sticky: at least one symbol was dropped
//   o_drop_cnt     out  16      only with QAM_DROP_CNT_EN: saturating count
//                               of dropped symbols
//
// Configuration macro:
//   QAM_DROP_CNT_EN  when defined, adds o_drop_cnt.
//
// Handshake (output side): a word transfers on a rising edge where
//   o_out_valid && i_out_ready. While o_out_valid=1 and i_out_ready=0 the
//   presented word is held stable, and o_out_valid only falls after a
//   transfer (or on reset). i_out_ready is ignored while o_out_valid=0.
// ============================================================================
module qam_symbol_mapper #(
    parameter int OUT_W      = 8,
    parameter int QAM_UNIT   = 32,
    parameter int QPSK_AMP   = 71,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [3:0]                      i_sym_in,
    input  logic                            i_sym_mod,
    input  logic                            i_sym_valid,
    input  logic                            i_out_ready,
    output logic                            o_out_valid,
    output logic signed [OUT_W-1:0]         o_i_out,
    output logic signed [OUT_W-1:0]         o_q_out,
    output logic                            o_out_mod,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level,
    output logic                            o_overflow
`ifdef QAM_DROP_CNT_EN
    ,
    output logic [15:0]                     o_drop_cnt
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int WORD_W  = 2 * OUT_W + 1;
    localparam int MAX_POS = (1 << (OUT_W - 1)) - 1;

    // ------------------------------------------------------------------
    // Elaboration-time sanity checks
    // ------------------------------------------------------------------
    generate
        if ((3 * QAM_UNIT) > MAX_POS || QPSK_AMP > MAX_POS) begin : g_bad_levels
            $error("qam_symbol_mapper: 3*QAM_UNIT or QPSK_AMP does not fit in OUT_W signed");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("qam_symbol_mapper: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    // Constellation levels, truncated to OUT_W bits
    localparam logic [OUT_W-1:0] C_QAM_P3  = OUT_W'(3 * QAM_UNIT);
    localparam logic [OUT_W-1:0] C_QAM_P1  = OUT_W'(QAM_UNIT);
    localparam logic [OUT_W-1:0] C_QAM_M1  = OUT_W'(-QAM_UNIT);
    localparam logic [OUT_W-1:0] C_QAM_M3  = OUT_W'(-3 * QAM_UNIT);
    localparam logic [OUT_W-1:0] C_QPSK_P  = OUT_W'(QPSK_AMP);
    localparam logic [OUT_W-1:0] C_QPSK_M  = OUT_W'(-QPSK_AMP);

    // Gray decode of one 16QAM axis: 00 -> -3U, 01 -> -1U, 11 -> +1U, 10 -> +3U
    function automatic logic [OUT_W-1:0] qam_axis(input logic [1:0] bits);
        logic [OUT_W-1:0] lvl;
        lvl = C_QAM_M3;
        case (bits)
            2'b00:   lvl = C_QAM_M3;
            2'b01:   lvl = C_QAM_M1;
            2'b11:   lvl = C_QAM_P1;
            2'b10:   lvl = C_QAM_P3;
            default: lvl = C_QAM_M3;
        endcase
        return lvl;
    endfunction

    // ------------------------------------------------------------------
    // Map stage
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] w_map_i_new;
    logic [OUT_W-1:0] w_map_q_new;

    // QPSK ignores bits [3:2]: I from bit 1, Q from bit 0
    assign w_map_i_new = i_sym_mod ? qam_axis(i_sym_in[3:2])
                                   : (i_sym_in[1] ? C_QPSK_P : C_QPSK_M);
    assign w_map_q_new = i_sym_mod ? qam_axis(i_sym_in[1:0])
                                   : (i_sym_in[0] ? C_QPSK_P : C_QPSK_M);

    logic             r_map_valid;
    logic             r_map_mod;
    logic [OUT_W-1:0] r_map_i;
    logic [OUT_W-1:0] r_map_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_map_valid <= 1'b0;
            r_map_mod   <= 1'b0;
            r_map_i     <= '0;
            r_map_q     <= '0;
        end else begin
            r_map_valid <= i_sym_valid;
            if (i_sym_valid) begin
                r_map_mod <= i_sym_mod;
                r_map_i   <= w_map_i_new;
                r_map_q   <= w_map_q_new;
            end
        end
    end

    logic [WORD_W-1:0] w_map_word;
    assign w_map_word = {r_map_mod, r_map_i, r_map_q};

    // ------------------------------------------------------------------
    // Output FIFO (first-word-fall-through)
    //   r_level counts every stored word, including the one presented on
    //   the output registers. The output registers always hold a copy of
    //   the storage head, refreshed from the post-edge head so a pop shows
    //   the next word on the same edge.
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_out_valid;
    logic              r_out_mod;
    logic [OUT_W-1:0]  r_out_i;
    logic [OUT_W-1:0]  r_out_q;
    logic              r_overflow;

    logic              w_full;
    logic              w_do_pop;
    logic              w_do_push;
    logic              w_drop;
    logic [LVL_W-1:0]  w_lvl_after_pop;
    logic [PTR_W-1:0]  w_rd_after_pop;
    logic [LVL_W-1:0]  w_level_next;
    logic [WORD_W-1:0] w_head_next;

    assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_do_pop  = r_out_valid && i_out_ready;
    // A push into a full FIFO still succeeds when the head leaves on the same edge
    assign w_do_push = r_map_valid && (!w_full || w_do_pop);
    assign w_drop    = r_map_valid && !w_do_push;

    assign w_lvl_after_pop = r_level - LVL_W'(w_do_pop);
    assign w_rd_after_pop  = r_rd_ptr + PTR_W'(w_do_pop);
    assign w_level_next    = w_lvl_after_pop + LVL_W'(w_do_push);

    // Head after this edge: the oldest remaining stored word, or the word
    // being pushed now when nothing else remains.
    assign w_head_next = (w_lvl_after_pop != '0) ? r_mem[w_rd_after_pop] : w_map_word;

    // Storage array carries no reset; r_level qualifies its contents
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= w_map_word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_level     <= '0;
            r_out_valid <= 1'b0;
            r_out_mod   <= 1'b0;
            r_out_i     <= '0;
            r_out_q     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of 2
            r_rd_ptr <= w_rd_after_pop;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_level     <= w_level_next;
            r_out_valid <= (w_level_next != '0);
            // When the FIFO drains, the last word stays on the data outputs
            if (w_level_next != '0) begin
                r_out_mod <= w_head_next[WORD_W-1];
                r_out_i   <= w_head_next[2*OUT_W-1:OUT_W];
                r_out_q   <= w_head_next[OUT_W-1:0];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef QAM_DROP_CNT_EN
    // Saturating count of dropped symbols
    logic [15:0] r_drop_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`else
    // Without the counter, drops are reported only by the sticky flag
`endif

    assign o_out_valid  = r_out_valid;
    assign o_i_out      = r_out_i;
    assign o_q_out      = r_out_q;
    assign o_out_mod    = r_out_mod;
    assign o_fifo_level = r_level;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// ============================================================================
// tb_qam_symbol_mapper
//   Directed bench: a table of single-symbol mapping vectors, then
//   hand-written sequences for mode switching, back-pressure, full-rate
//   streaming, overflow and reset during traffic.
// ============================================================================
module tb_qam_symbol_mapper;

    localparam int OUT_W = 8;
    localparam int W     = 2 * OUT_W + 1;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        sym_in;
    logic              sym_mod;
    logic              sym_valid;
    logic              out_ready;
    logic              out_valid;
    logic [OUT_W-1:0]  i_out;
    logic [OUT_W-1:0]  q_out;
    logic              out_mod;
    logic [2:0]        fifo_level;
    logic              overflow;
`ifdef QAM_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    always #5 clk = ~clk;

    qam_symbol_mapper dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sym_in     (sym_in),
        .i_sym_mod    (sym_mod),
        .i_sym_valid  (sym_valid),
        .i_out_ready  (out_ready),
        .o_out_valid  (out_valid),
        .o_i_out      (i_out),
        .o_q_out      (q_out),
        .o_out_mod    (out_mod),
        .o_fifo_level (fifo_level),
        .o_overflow   (overflow)
`ifdef QAM_DROP_CNT_EN
        ,
        .o_drop_cnt   (drop_cnt)
`endif
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        string      name;
        logic       mod;
        logic [3:0] sym;
        int         exp_i;
        int         exp_q;
    } vec_t;

    vec_t vecs[10];

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference mapping: Gray-to-binary, then level = (2*bin - 3) * unit
    function automatic int ref_axis(input logic [1:0] b);
        logic [1:0] bin;
        bin = {b[1], b[1] ^ b[0]};
        return (2 * int'(bin) - 3) * 32;
    endfunction

    function automatic logic [W-1:0] ref_map(input logic m, input logic [3:0] s);
        int iv;
        int qv;
        if (m) begin
            iv = ref_axis(s[3:2]);
            qv = ref_axis(s[1:0]);
        end else begin
            iv = s[1] ? 71 : -71;
            qv = s[0] ? 71 : -71;
        end
        return {m, 8'(iv), 8'(qv)};
    endfunction

    // Compare presented word against the oldest expected entry
    function automatic void check_head(input string name);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: output word %h with empty expected queue", name, {out_mod, i_out, q_out});
        end else begin
            e = exp_q.pop_front();
            check(name, int'({out_mod, i_out, q_out}), int'(e));
        end
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sym(input logic m, input logic [3:0] s);
        sym_valid = 1'b1;
        sym_mod   = m;
        sym_in    = s;
    endtask

    task automatic idle_sym();
        sym_valid = 1'b0;
        sym_mod   = 1'b0;
        sym_in    = 4'h0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic saw_valid;
        int   rcvd;

        vecs[0] = '{"t2_1001", 1'b1, 4'b1001,  96, -32};
        vecs[1] = '{"t2_0111", 1'b1, 4'b0111, -32,  32};
        vecs[2] = '{"t2_0000", 1'b1, 4'b0000, -96, -96};
        vecs[3] = '{"t2_1111", 1'b1, 4'b1111,  32,  32};
        vecs[4] = '{"t2_1010", 1'b1, 4'b1010,  96,  96};
        vecs[5] = '{"t2_0110", 1'b1, 4'b0110, -32,  96};
        vecs[6] = '{"t3_1110", 1'b0, 4'b1110,  71, -71};
        vecs[7] = '{"t3_0001", 1'b0, 4'b0001, -71,  71};
        vecs[8] = '{"t3_0011", 1'b0, 4'b0011,  71,  71};
        vecs[9] = '{"t3_1100", 1'b0, 4'b1100, -71, -71};

        rst       = 1'b1;
        out_ready = 1'b0;
        idle_sym();
        step();
        step();
        check("rst_valid", int'(out_valid), 0);
        check("rst_i", int'(i_out), 0);
        check("rst_q", int'(q_out), 0);
        check("rst_mod", int'(out_mod), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_ovf", int'(overflow), 0);
        rst = 1'b0;
        step();

        // ---- Single-symbol table: exact 2-cycle latency, then drain ----
        out_ready = 1'b1;
        for (int v = 0; v < 10; v++) begin
            drive_sym(vecs[v].mod, vecs[v].sym);
            step();
            idle_sym();
            check({vecs[v].name, "_early"}, int'(out_valid), 0);
            step();
            check({vecs[v].name, "_valid"}, int'(out_valid), 1);
            check({vecs[v].name, "_i"}, int'($signed(i_out)), vecs[v].exp_i);
            check({vecs[v].name, "_q"}, int'($signed(q_out)), vecs[v].exp_q);
            check({vecs[v].name, "_mod"}, int'(out_mod), int'(vecs[v].mod));
            check({vecs[v].name, "_lvl"}, int'(fifo_level), 1);
            step();
            check({vecs[v].name, "_gone"}, int'(out_valid), 0);
        end

        // ---- Mode switch on consecutive groups ----
        drive_sym(1'b0, 4'b1110);
        step();
        drive_sym(1'b1, 4'b0000);
        step();
        idle_sym();
        check("sw_qpsk_i", int'($signed(i_out)), 71);
        check("sw_qpsk_q", int'($signed(q_out)), -71);
        check("sw_qpsk_mod", int'(out_mod), 0);
        step();
        check("sw_qam_i", int'($signed(i_out)), -96);
        check("sw_qam_q", int'($signed(q_out)), -96);
        check("sw_qam_mod", int'(out_mod), 1);
        step();
        check("sw_empty", int'(out_valid), 0);

        // ---- Back-pressure: 4 symbols held, then drained in order ----
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_sym(k[0], 4'(3 * k + 5));
            exp_q.push_back(ref_map(k[0], 4'(3 * k + 5)));
            step();
        end
        idle_sym();
        step();
        step();
        check("bp_level", int'(fifo_level), 4);
        check("bp_valid", int'(out_valid), 1);
        check("bp_hold0", int'({out_mod, i_out, q_out}), int'(exp_q[0]));
        step();
        step();
        check("bp_hold1", int'({out_mod, i_out, q_out}), int'(exp_q[0]));
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_out_valid", int'(out_valid), 1);
            check_head("bp_out_word");
            step();
        end
        check("bp_drained", int'(out_valid), 0);
        check("bp_drained_lvl", int'(fifo_level), 0);

        // ---- Full-rate stream of 64 symbols ----
        exp_q.delete();
        rcvd = 0;
        for (int c = 0; c < 72; c++) begin
            if (c < 64) begin
                drive_sym(c % 3 != 0, 4'(c * 7));
                exp_q.push_back(ref_map(c % 3 != 0, 4'(c * 7)));
            end else begin
                idle_sym();
            end
            step();
            if (c == 30) check("fr_level", int'(fifo_level), 1);
            if (out_valid) begin
                check_head("fr_word");
                rcvd++;
            end
        end
        check("fr_count", rcvd, 64);
        check("fr_left", exp_q.size(), 0);
        check("fr_ovf", int'(overflow), 0);

        // ---- Overflow: 6 pushes into a 4-deep FIFO ----
        exp_q.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_sym(1'b1, 4'(k + 9));
            if (k < 4) exp_q.push_back(ref_map(1'b1, 4'(k + 9)));
            step();
        end
        idle_sym();
        step();
        step();
        check("ov_level", int'(fifo_level), 4);
        check("ov_flag", int'(overflow), 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("ov_out_valid", int'(out_valid), 1);
            check_head("ov_out_word");
            step();
        end
        check("ov_drained", int'(out_valid), 0);
        check("ov_sticky", int'(overflow), 1);
`ifdef QAM_DROP_CNT_EN
        check("ov_drop_cnt", int'(drop_cnt), 2);
`endif

        // ---- Reset during traffic ----
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_sym(1'b0, 4'(k));
            step();
        end
        rst = 1'b1;
        drive_sym(1'b1, 4'hA);
        step();
        step();
        check("t1_valid", int'(out_valid), 0);
        check("t1_i", int'(i_out), 0);
        check("t1_q", int'(q_out), 0);
        check("t1_mod", int'(out_mod), 0);
        check("t1_level", int'(fifo_level), 0);
        check("t1_ovf", int'(overflow), 0);
`ifdef QAM_DROP_CNT_EN
        check("t1_drop_cnt", int'(drop_cnt), 0);
`endif
        rst = 1'b0;
        idle_sym();
        out_ready = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        check("t1_no_stale", int'(saw_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
